sha_256_padder: RTL

SHA_256_PADDER -- requirements
Module: sha_256_padder

---
 rtl/sha_256_pkg.sv | 32 +++
 rtl/sha_256_pad_gen.sv | 38 +++
 rtl/sha_256_padder.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/sha_256_pkg.sv
// Shared types and constants for the SHA-256 message padder.
// Holds the padder FSM states, pad-generator modes and the length-field helper.
package sha_256_pkg;

  localparam int         BLOCK_BYTES = 64;
  localparam int         LEN_OFFSET  = 56;
  localparam logic [7:0] PAD_BYTE    = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    PAD,
    XTRA,
    ISSUE,
    WAIT
  } state_t;

  // PM_SHORT: pad+length fit, PM_SPILL: pad only, PM_FULL: untouched,
  // PM_XTRA_PAD / PM_XTRA_LEN: fresh trailing block with / without the pad byte.
  typedef enum logic [2:0] {
    PM_SHORT,
    PM_SPILL,
    PM_FULL,
    PM_XTRA_PAD,
    PM_XTRA_LEN
  } pad_mode_t;

  function automatic logic [63:0] len_field(input logic [31:0] byte_cnt);
    return {29'b0, byte_cnt, 3'b0};
  endfunction

endpackage

// File: rtl/sha_256_pad_gen.sv
// Combinational pad/length insertion for one 512-bit block.
// Byte k of the block sits at bits [511-8k -: 8].
module sha_256_pad_gen
  import sha_256_pkg::*;
(
  input  logic [511:0] i_block,
  input  logic [6:0]   i_p,
  input  logic [31:0]  i_byte_cnt,
  input  pad_mode_t    i_mode,
  output logic [511:0] o_block
);

  logic [63:0] w_len;

  assign w_len = len_field(i_byte_cnt);

  always_comb begin
    o_block = i_block;
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      if (k >= LEN_OFFSET && i_mode != PM_SPILL && i_mode != PM_FULL) begin
        o_block[511-8*k -: 8] = w_len[63-8*(k-LEN_OFFSET) -: 8];
      end else begin
        case (i_mode)
          PM_SHORT, PM_SPILL: begin
            if (7'(k) == i_p)
              o_block[511-8*k -: 8] = PAD_BYTE;
            else if (7'(k) > i_p)
              o_block[511-8*k -: 8] = 8'h00;
          end
          PM_XTRA_PAD: o_block[511-8*k -: 8] = (k == 0) ? PAD_BYTE : 8'h00;
          PM_XTRA_LEN: o_block[511-8*k -: 8] = 8'h00;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/sha_256_padder.sv
// SHA-256 byte-stream padder: packs bytes into 512-bit blocks, appends pad and
// length, and hands each block to the hash core with a start/done handshake.
//
// state | meaning
// IDLE  | waiting for the first byte of a message
// FILL  | collecting bytes into the current block
// PAD   | one cycle: insert pad byte / length into the current block
// XTRA  | one cycle: build the trailing zero+length block
// ISSUE | one-cycle block_start to the hash core
// WAIT  | block held stable until hash_ready
module sha_256_padder
  import sha_256_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  input  logic         in_last,
  output logic         in_ready,
  output logic [511:0] block_data,
  output logic         block_start,
  input  logic         hash_ready,
  output logic         msg_done,
  output logic         busy
);

  state_t       r_state;
  state_t       w_next_state;
  logic [5:0]   r_idx;
  logic [6:0]   r_p;
  logic [31:0]  r_byte_cnt;
  logic [511:0] r_block;
  logic         r_final;
  logic         r_extra;
  logic         r_owed;
  logic         r_msg_done;

  logic         w_accept;
  logic [511:0] w_block_wr;
  logic [511:0] w_pad_block;
  pad_mode_t    w_pad_mode;

  assign w_accept = in_valid && in_ready;

  always_comb begin
    w_block_wr = r_block;
    for (int k = 0; k < BLOCK_BYTES; k++) begin
      if (6'(k) == r_idx)
        w_block_wr[511-8*k -: 8] = in_data;
    end
  end

  always_comb begin
    if (r_state == XTRA)
      w_pad_mode = r_owed ? PM_XTRA_PAD : PM_XTRA_LEN;
    else if (r_p <= 7'(LEN_OFFSET - 1))
      w_pad_mode = PM_SHORT;
    else if (r_p == 7'(BLOCK_BYTES))
      w_pad_mode = PM_FULL;
    else
      w_pad_mode = PM_SPILL;
  end

  sha_256_pad_gen u_pad_gen (
    .i_block    (r_block),
    .i_p        (r_p),
    .i_byte_cnt (r_byte_cnt),
    .i_mode     (w_pad_mode),
    .o_block    (w_pad_block)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_state <= IDLE;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept)
          w_next_state = in_last ? PAD : FILL;
      end
      FILL: begin
        if (w_accept) begin
          if (in_last)
            w_next_state = PAD;
          else if (r_idx == 6'(BLOCK_BYTES - 1))
            w_next_state = ISSUE;
        end
      end
      PAD:   w_next_state = ISSUE;
      XTRA:  w_next_state = ISSUE;
      ISSUE: w_next_state = WAIT;
      WAIT: begin
        if (hash_ready) begin
          if (r_final)
            w_next_state = IDLE;
          else if (r_extra)
            w_next_state = XTRA;
          else
            w_next_state = FILL;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = rstn && (r_state == IDLE || r_state == FILL);
    block_start = (r_state == ISSUE);
    busy        = (r_state != IDLE);
    msg_done    = r_msg_done;
    block_data  = r_block;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_idx      <= '0;
      r_p        <= '0;
      r_byte_cnt <= '0;
      r_block    <= '0;
      r_final    <= 1'b0;
      r_extra    <= 1'b0;
      r_owed     <= 1'b0;
      r_msg_done <= 1'b0;
    end else begin
      r_msg_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_final <= 1'b0;
          r_extra <= 1'b0;
          r_owed  <= 1'b0;
          if (w_accept) begin
            r_block    <= w_block_wr;
            r_idx      <= r_idx + 6'd1;
            r_p        <= {1'b0, r_idx} + 7'd1;
            r_byte_cnt <= 32'd1;
          end else begin
            r_idx      <= '0;
            r_byte_cnt <= '0;
          end
        end
        FILL: begin
          if (w_accept) begin
            r_block    <= w_block_wr;
            r_idx      <= r_idx + 6'd1;
            r_p        <= {1'b0, r_idx} + 7'd1;
            r_byte_cnt <= r_byte_cnt + 32'd1;
          end
        end
        PAD: begin
          r_block <= w_pad_block;
          if (w_pad_mode == PM_SHORT) begin
            r_final <= 1'b1;
          end else begin
            r_extra <= 1'b1;
            r_owed  <= (w_pad_mode == PM_FULL);
          end
        end
        XTRA: begin
          r_block <= w_pad_block;
          r_final <= 1'b1;
          r_extra <= 1'b0;
          r_owed  <= 1'b0;
        end
        WAIT: begin
          // idx must be 0 on every exit, including a back-to-back first byte in IDLE
          if (hash_ready) begin
            r_idx <= '0;
            if (r_final)
              r_msg_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
